inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache_pkg.sv | 16 +
 rtl/icache_array.sv | 54 +++++
 rtl/inst_cache.sv | 150 +++++++++++++++
 tb/tb_inst_cache.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared instruction-cache definitions. The memory controller imports the
// same package so the block geometry and FSM encodings agree on both sides.
package inst_cache_pkg;

  localparam int BLOCK_WIDTH = 1;                 // log2 instructions per block
  localparam int BLOCK_SIZE  = 2;                 // instructions per block
  localparam int CACHE_WIDTH = 8;                 // log2 blocks
  localparam int BLOCK_NUM   = 1 << CACHE_WIDTH;  // number of lines
  localparam int ADDR_WIDTH  = 32;                // byte address width

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (clears valid bits only)
//   we_i         - write strobe: install wr_tag_i/wr_block_i at wr_idx_i, set valid
//   wr_idx_i     - write line index
//   wr_tag_i     - tag to store
//   wr_block_i   - block data to store
//   rd_idx_i     - combinational read line index
//   rd_valid_o   - valid bit of the indexed line
//   rd_tag_o     - tag of the indexed line
//   rd_block_o   - block data of the indexed line
module icache_array #(
  parameter int BLOCK_NUM = 256,
  parameter int IDX_W     = 8,
  parameter int TAG_W     = 21,
  parameter int BLK_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [BLK_W-1:0] wr_block_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [BLK_W-1:0] rd_block_o
);

  logic [BLOCK_NUM-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [BLOCK_NUM];
  logic [BLK_W-1:0]     data_q [BLOCK_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data are never reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_block_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_block_o = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between the fetch stage and the memory
// controller. Hits answer one cycle after the request; misses issue a block
// refill and answer one cycle after the refill returns.
// Ports:
//   Sys_clk, Sys_rst   - clock, asynchronous active-high reset
//   Sys_rdy            - global enable; all state holds while low
//   Clr                - pipeline flush
//   IFIC_en/IFIC_addr  - fetch request (level, held until answered) and PC
//   ICIF_en/ICIF_inst  - instruction valid pulse and instruction
//   ICMC_en/ICMC_addr  - refill request and block base address
//   MCIC_en/MCIC_block - refill-done pulse and block data (word 0 in low bits)
module inst_cache #(
  parameter int BLOCK_WIDTH = inst_cache_pkg::BLOCK_WIDTH,
  parameter int BLOCK_SIZE  = inst_cache_pkg::BLOCK_SIZE,
  parameter int CACHE_WIDTH = inst_cache_pkg::CACHE_WIDTH,
  parameter int ADDR_WIDTH  = inst_cache_pkg::ADDR_WIDTH
) (
  input  logic                     Sys_clk,
  input  logic                     Sys_rst,
  input  logic                     Sys_rdy,
  input  logic                     Clr,
  input  logic                     IFIC_en,
  input  logic [ADDR_WIDTH-1:0]    IFIC_addr,
  output logic                     ICIF_en,
  output logic [31:0]              ICIF_inst,
  output logic                     ICMC_en,
  output logic [ADDR_WIDTH-1:0]    ICMC_addr,
  input  logic                     MCIC_en,
  input  logic [32*BLOCK_SIZE-1:0] MCIC_block
);

  import inst_cache_pkg::*;

  localparam int LINES   = 1 << CACHE_WIDTH;
  localparam int IDX_LSB = BLOCK_WIDTH + 2;
  localparam int TAG_LSB = IDX_LSB + CACHE_WIDTH;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam int BLK_W   = 32 * BLOCK_SIZE;

  function automatic logic [31:0] select_word(input logic [BLK_W-1:0]       blk,
                                              input logic [BLOCK_WIDTH-1:0] sel);
    return blk[32*sel +: 32];
  endfunction

  ic_state_e               state_q, state_d;
  logic                    discard_q, discard_d;
  logic                    icif_en_q, icif_en_d;
  logic [31:0]             inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]   icmc_addr_q, icmc_addr_d;
  logic [BLOCK_WIDTH-1:0]  wsel_q, wsel_d;

  logic                    wr_en;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [BLK_W-1:0]        rd_block;
  logic                    hit;

  logic [CACHE_WIDTH-1:0]  req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [BLOCK_WIDTH-1:0]  req_sel;
  logic                    unused_bits;

  assign req_idx     = IFIC_addr[TAG_LSB-1:IDX_LSB];
  assign req_tag     = IFIC_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_sel     = IFIC_addr[IDX_LSB-1:2];
  assign unused_bits = ^IFIC_addr[1:0];

  icache_array #(
    .BLOCK_NUM (LINES),
    .IDX_W     (CACHE_WIDTH),
    .TAG_W     (TAG_W),
    .BLK_W     (BLK_W)
  ) u_array (
    .clk        (Sys_clk),
    .rst        (Sys_rst),
    .we_i       (wr_en && Sys_rdy),
    .wr_idx_i   (icmc_addr_q[TAG_LSB-1:IDX_LSB]),
    .wr_tag_i   (icmc_addr_q[ADDR_WIDTH-1:TAG_LSB]),
    .wr_block_i (MCIC_block),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_block_o (rd_block)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    icif_en_d   = 1'b0;
    inst_d      = inst_q;
    icmc_addr_d = icmc_addr_q;
    wsel_d      = wsel_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        // A request still high while its answer is on the bus is stale.
        if (IFIC_en && !icif_en_q && !Clr) begin
          if (hit) begin
            icif_en_d = 1'b1;
            inst_d    = select_word(rd_block, req_sel);
          end else begin
            icmc_addr_d = {IFIC_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
            wsel_d      = req_sel;
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        if (Clr) discard_d = 1'b1;
        if (MCIC_en) begin
          // The line is installed even when the fetch was flushed.
          wr_en     = 1'b1;
          icif_en_d = !(discard_q || Clr);
          inst_d    = select_word(MCIC_block, wsel_q);
          discard_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      icif_en_q   <= 1'b0;
      inst_q      <= '0;
      icmc_addr_q <= '0;
      wsel_q      <= '0;
    end else if (Sys_rdy) begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      icif_en_q   <= icif_en_d;
      inst_q      <= inst_d;
      icmc_addr_q <= icmc_addr_d;
      wsel_q      <= wsel_d;
    end
  end

  // Dropped in the refill-done cycle so the controller never sees a
  // request as it goes idle.
  assign ICMC_en   = (state_q == MISS) && !MCIC_en;
  assign ICMC_addr = icmc_addr_q;
  assign ICIF_en   = icif_en_q;
  assign ICIF_inst = inst_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed testbench for inst_cache with an expected-instruction scoreboard.
module tb_inst_cache;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst = 1'b1;
  logic        Sys_rdy = 1'b1;
  logic        Clr = 1'b0;
  logic        IFIC_en = 1'b0;
  logic [31:0] IFIC_addr = '0;
  logic        ICIF_en;
  logic [31:0] ICIF_inst;
  logic        ICMC_en;
  logic [31:0] ICMC_addr;
  logic        MCIC_en = 1'b0;
  logic [63:0] MCIC_block = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  localparam logic [63:0] B1 = {32'h00100073, 32'h00C00093};
  localparam logic [63:0] B2 = {32'hBBBB0002, 32'hAAAA0001};
  localparam logic [63:0] B3 = {32'hDDDD0004, 32'hCCCC0003};
  localparam logic [63:0] JUNK = {32'hFFFF1111, 32'hEEEE2222};

  inst_cache dut (
    .Sys_clk    (Sys_clk),
    .Sys_rst    (Sys_rst),
    .Sys_rdy    (Sys_rdy),
    .Clr        (Clr),
    .IFIC_en    (IFIC_en),
    .IFIC_addr  (IFIC_addr),
    .ICIF_en    (ICIF_en),
    .ICIF_inst  (ICIF_inst),
    .ICMC_en    (ICMC_en),
    .ICMC_addr  (ICMC_addr),
    .MCIC_en    (MCIC_en),
    .MCIC_block (MCIC_block)
  );

  always #5 Sys_clk = ~Sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next ICIF_en pulse and scores it against the queue.
  task automatic expect_resp(input string tag, input int exp_lat);
    int lat;
    logic [31:0] e;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Sys_clk);
      if (ICIF_en) begin
        lat = i;
        break;
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_inst"}, ICIF_inst, e);
  endtask

  task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    IFIC_addr = addr;
    IFIC_en   = 1'b1;
    exp_q.push_back(exp);
    expect_resp(tag, 1);
    chk({tag, "_no_refill"}, ICMC_en, 1'b0);
    IFIC_en = 1'b0;
    @(negedge Sys_clk);
    chk({tag, "_pulse_end"}, ICIF_en, 1'b0);
  endtask

  task automatic miss_refill(input string tag, input logic [31:0] addr, input logic [31:0] base,
                             input logic [63:0] blk, input logic [31:0] exp);
    IFIC_addr = addr;
    IFIC_en   = 1'b1;
    @(negedge Sys_clk);
    chk({tag, "_req"}, ICMC_en, 1'b1);
    chk({tag, "_addr"}, ICMC_addr, base);
    chk({tag, "_no_inst"}, ICIF_en, 1'b0);
    @(negedge Sys_clk);
    chk({tag, "_addr_stable"}, ICMC_addr, base);
    MCIC_block = blk;
    MCIC_en    = 1'b1;
    exp_q.push_back(exp);
    #1;
    chk({tag, "_req_drop"}, ICMC_en, 1'b0);
    expect_resp(tag, 1);
    MCIC_en = 1'b0;
    IFIC_en = 1'b0;
    @(negedge Sys_clk);
    chk({tag, "_pulse_end"}, ICIF_en, 1'b0);
    chk({tag, "_idle"}, ICMC_en, 1'b0);
  endtask

  initial begin
    int n;
    // Reset state
    @(negedge Sys_clk);
    @(negedge Sys_clk);
    chk("rst_icif_en", ICIF_en, 1'b0);
    chk("rst_inst", ICIF_inst, 32'h0);
    chk("rst_icmc_en", ICMC_en, 1'b0);
    chk("rst_icmc_addr", ICMC_addr, 32'h0);
    Sys_rst = 1'b0;
    @(negedge Sys_clk);
    chk("post_rst_icif_en", ICIF_en, 1'b0);

    // Cold miss, then hits on both words
    miss_refill("cold", 32'h00000104, 32'h00000100, B1, 32'h00100073);
    fetch_hit("hit0", 32'h00000100, 32'h00C00093);
    fetch_hit("hit1", 32'h00000104, 32'h00100073);

    // Conflict: same index, tag 1 evicts the line
    miss_refill("conflict", 32'h00000900, 32'h00000900, B2, 32'hAAAA0001);
    fetch_hit("conflict_hit", 32'h00000904, 32'hBBBB0002);

    // Re-miss on 0x100, flushed while in MISS
    IFIC_addr = 32'h00000100;
    IFIC_en   = 1'b1;
    @(negedge Sys_clk);
    chk("remiss_req", ICMC_en, 1'b1);
    chk("remiss_addr", ICMC_addr, 32'h00000100);
    Clr     = 1'b1;
    IFIC_en = 1'b0;
    @(negedge Sys_clk);
    Clr = 1'b0;
    chk("flush_still_miss", ICMC_en, 1'b1);
    MCIC_block = B1;
    MCIC_en    = 1'b1;
    @(negedge Sys_clk);
    MCIC_en = 1'b0;
    n = ICIF_en ? 1 : 0;
    repeat (3) begin
      @(negedge Sys_clk);
      if (ICIF_en) n++;
    end
    chk("flush_no_pulse", n, 0);
    fetch_hit("flush_then_hit", 32'h00000104, 32'h00100073);

    // Clr in IDLE suppresses a hit that cycle only
    IFIC_addr = 32'h00000100;
    IFIC_en   = 1'b1;
    Clr       = 1'b1;
    @(negedge Sys_clk);
    chk("clr_idle_suppress", ICIF_en, 1'b0);
    Clr = 1'b0;
    exp_q.push_back(32'h00C00093);
    expect_resp("clr_idle_after", 1);
    IFIC_en = 1'b0;
    @(negedge Sys_clk);

    // Held request: exactly one pulse
    IFIC_addr = 32'h00000104;
    IFIC_en   = 1'b1;
    exp_q.push_back(32'h00100073);
    expect_resp("held", 1);
    @(negedge Sys_clk);
    chk("held_second_ignored", ICIF_en, 1'b0);
    IFIC_en = 1'b0;
    @(negedge Sys_clk);
    chk("held_quiet", ICIF_en, 1'b0);

    // Stall before the hit, then stall while the pulse is up
    IFIC_addr = 32'h00000100;
    IFIC_en   = 1'b1;
    Sys_rdy   = 1'b0;
    exp_q.push_back(32'h00C00093);
    n = 0;
    repeat (3) begin
      @(negedge Sys_clk);
      if (ICIF_en) n++;
    end
    chk("stall_no_pulse", n, 0);
    Sys_rdy = 1'b1;
    expect_resp("stall", 1);
    Sys_rdy = 1'b0;
    IFIC_en = 1'b0;
    @(negedge Sys_clk);
    chk("stall_hold_pulse", ICIF_en, 1'b1);
    Sys_rdy = 1'b1;
    @(negedge Sys_clk);
    chk("stall_release", ICIF_en, 1'b0);

    // MCIC_en while idle is ignored
    MCIC_block = JUNK;
    MCIC_en    = 1'b1;
    @(negedge Sys_clk);
    MCIC_en = 1'b0;
    chk("idle_mcic_no_pulse", ICIF_en, 1'b0);
    chk("idle_mcic_no_req", ICMC_en, 1'b0);
    fetch_hit("idle_mcic_hit", 32'h00000104, 32'h00100073);

    // Reset during MISS abandons the refill and clears valid bits
    IFIC_addr = 32'h00002004;
    IFIC_en   = 1'b1;
    @(negedge Sys_clk);
    chk("rmiss_req", ICMC_en, 1'b1);
    chk("rmiss_addr", ICMC_addr, 32'h00002000);
    IFIC_en = 1'b0;
    Sys_rst = 1'b1;
    #1;
    chk("rmiss_req_cleared", ICMC_en, 1'b0);
    chk("rmiss_addr_cleared", ICMC_addr, 32'h0);
    @(negedge Sys_clk);
    Sys_rst    = 1'b0;
    MCIC_block = B3;
    MCIC_en    = 1'b1;
    #1;
    chk("rmiss_late_mcic_req", ICMC_en, 1'b0);
    @(negedge Sys_clk);
    MCIC_en = 1'b0;
    chk("rmiss_late_mcic_pulse", ICIF_en, 1'b0);
    miss_refill("after_rst", 32'h00000104, 32'h00000100, B1, 32'h00100073);
    miss_refill("abandoned", 32'h00002000, 32'h00002000, B3, 32'hCCCC0003);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
